instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential MIPS instruction encoder and program loader: accepts decoded instruction requests (kind plus register/immediate fields) over a valid/ready handshake and packs them into 32-bit MIPS words. It writes the words into instruction memory at consecutive word addresses. It sits in front of the instruction memory, upstream of fetch, and emits exactly the opcodes the control unit decodes: R-type 6'h00, ADDI 6'h08, ORI 6'h0D.

## Interface
- ADDR_WIDTH, 8, word-address width of instruction memory
- BASE_ADDR, 0, word address loaded into the address counter by reset and by `start`
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  synchronous pulse; reload address counter to BASE_ADDR, clear `count`, `full`, `err`
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at rising edge
- req_kind  in  2  0 = R-type, 1 = ADDI, 2 = ORI, 3 = illegal
- req_rs, req_rt, req_rd, req_shamt  in  5 each  register/shift fields
- req_funct  in  6  R-type funct
- req_imm  in  16  immediate for ADDI/ORI
- mem_we  out  1  write strobe, held until mem_ready
- mem_addr  out  ADDR_WIDTH  word address of the write
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  memory accepts the write this cycle
- count  out  ADDR_WIDTH+1  words accepted since reset/start
- full  out  1  last address consumed; no further requests accepted
- err  out  1  sticky encoding error (0 unless INSTR_ENC_CHECK_EN)

## Operation
- Encoding: R-type {6'h00, rs, rt, rd, shamt, funct}; ADDI {6'h08, rs, rt, imm}; ORI {6'h0D, rs, rt, imm}. Field widths are exact; no sign extension in the encoder.
- FSM states:
  - EMPTY: no write pending, mem_we=0.
  - HOLD: mem_we=1, waiting on mem_ready.
  - DONE: full=1.
- Transitions:
  - EMPTY→HOLD on accept.
  - HOLD→EMPTY on mem_ready without a new accept.
  - HOLD→HOLD on mem_ready with a simultaneous accept (back-to-back, one word per cycle).
  - Any→DONE once the write at address 2^ADDR_WIDTH−1 has been accepted and, if HOLD, drained.
- req_ready = !full && !start && (state==EMPTY || mem_ready).
- On accept: mem_wdata and mem_addr are registered from the encoding and the counter; counter and `count` increment. The counter does not wrap: accepting at the top address sets `full`.
- `start` has priority over a simultaneous request; that request is not accepted. A pending HOLD write still completes at its latched address. `start` exits DONE to EMPTY/HOLD accordingly.
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, req_ready=0 during reset, state EMPTY.
- Reset mid-HOLD discards the pending write.

## Timing
- Latency: request accepted at edge N → mem_we/mem_wdata valid after edge N, observable in cycle N+1.
- Throughput: 1 word/cycle while mem_ready is held high.
- mem_wdata and mem_addr are stable while mem_we=1 and mem_ready=0.
- All outputs are registered except req_ready, which is combinational from state, start, and mem_ready.

## Configuration
- INSTR_ENC_CHECK_EN defined:
  - req_kind==3, or rt==0 for ADDI/ORI, or rd==0 for R-type → request is accepted (consumed) but nothing is written, the counter does not advance, and `err` is set sticky until start/reset.
- Not defined:
  - kind 3 encodes as 32'h0000_0000 (NOP) and is written normally.
  - $zero destinations are encoded as given.
  - `err` is tied 0.

## Structure
- Package `mips_enc_pkg`:
  - kind codes
  - opcode constants R_TYPE=6'h00, ADDI=6'h08, ORI=6'h0D (shared with the control unit)
  - funct constants ADD=6'h20, SUB=6'h22, AND=6'h24, OR=6'h25, NOR=6'h27, SLT=6'h2A
- One combinational sub-module `mips_instr_pack` (fields → 32-bit word, plus legality flag). The FSM, counter and handshake stay in `instr_encoder`.

## Test plan
- Reset, then R-type rs=1 rt=2 rd=3 shamt=0 funct=6'h20 with mem_ready=1 → mem_we=1 next cycle, mem_addr=0, mem_wdata=32'h00221820, count=1.
- ADDI rs=0 rt=8 imm=16'h0005 then ORI rs=8 rt=9 imm=16'h00FF back-to-back → 32'h20080005 at addr 0, 32'h350900FF at addr 1, no idle cycle.
- mem_ready held 0 for 3 cycles during HOLD → req_ready=0, mem_wdata/mem_addr unchanged; a new request is accepted in the same cycle mem_ready rises.
- ADDR_WIDTH=2, issue 5 requests → addresses 0..3 written, full=1 after the 4th, 5th never accepted; `start` → full=0, count=0, next write at BASE_ADDR.
- `start` and req_valid in the same cycle → request not accepted, counter at BASE_ADDR; request accepted the next cycle at BASE_ADDR.
- req_kind=3: with INSTR_ENC_CHECK_EN → no mem_we, err=1, count unchanged; without → 32'h00000000 written, err=0.

Source files
------------

// File: rtl/mips_enc_pkg.sv
// rtl/mips_enc_pkg.sv - shared MIPS encoding constants, request kinds and encoder states
package mips_enc_pkg;

  typedef enum logic [1:0] {
    KIND_R    = 2'd0,
    KIND_ADDI = 2'd1,
    KIND_ORI  = 2'd2,
    KIND_ILL  = 2'd3
  } req_kind_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DONE  = 2'd2
  } enc_state_e;

  // Opcodes decoded by the control unit
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ORI    = 6'h0D;

  localparam logic [5:0] ADD = 6'h20;
  localparam logic [5:0] SUB = 6'h22;
  localparam logic [5:0] AND = 6'h24;
  localparam logic [5:0] OR  = 6'h25;
  localparam logic [5:0] NOR = 6'h27;
  localparam logic [5:0] SLT = 6'h2A;

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - request handshake and instruction-memory write bus
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_kind;
  logic [4:0]            req_rs;
  logic [4:0]            req_rt;
  logic [4:0]            req_rd;
  logic [4:0]            req_shamt;
  logic [5:0]            req_funct;
  logic [15:0]           req_imm;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_ready;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm,
    output mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd, req_shamt, req_funct, req_imm,
    input  mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_instr_pack.sv
// rtl/mips_instr_pack.sv - combinational packer from request fields to a 32-bit MIPS word
module mips_instr_pack
  import mips_enc_pkg::*;
#(
  parameter bit CHECK_EN = 1'b0
) (
  input  logic [1:0]  kind_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  output logic [31:0] word_o,
  output logic        legal_o
);
  logic dest_ok;

  always_comb begin
    word_o = 32'h0000_0000;
    case (req_kind_e'(kind_i))
      KIND_R:    word_o = {R_TYPE, rs_i, rt_i, rd_i, shamt_i, funct_i};
      KIND_ADDI: word_o = {ADDI, rs_i, rt_i, imm_i};
      KIND_ORI:  word_o = {ORI, rs_i, rt_i, imm_i};
      default:   word_o = 32'h0000_0000;
    endcase
  end

  // Writing $zero is pointless, so the checked build rejects it alongside kind 3
  assign dest_ok = (kind_i == KIND_R) ? (rd_i != 5'd0) : (rt_i != 5'd0);
  assign legal_o = CHECK_EN ? ((kind_i != KIND_ILL) && dest_ok) : 1'b1;

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS instruction encoder and sequential instruction-memory loader
// Optional request legality checking is enabled by defining INSTR_ENC_CHECK_EN.
module instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_encoder_if.slave      bus,
  output logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                err
);
`ifdef INSTR_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] TOP      = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  enc_state_e            state_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  full_q;
  logic                  err_q;

  logic [31:0] word;
  logic        legal;
  logic        req_ready;
  logic        accept;
  logic        write;

  mips_instr_pack #(.CHECK_EN(CHECK_EN)) u_pack (
    .kind_i  (bus.req_kind),
    .rs_i    (bus.req_rs),
    .rt_i    (bus.req_rt),
    .rd_i    (bus.req_rd),
    .shamt_i (bus.req_shamt),
    .funct_i (bus.req_funct),
    .imm_i   (bus.req_imm),
    .word_o  (word),
    .legal_o (legal)
  );

  // Gated by reset so nothing is offered while the block is held in reset
  assign req_ready = reset && !full_q && !start && ((state_q == ST_EMPTY) || bus.mem_ready);
  assign accept    = bus.req_valid && req_ready;
  assign write     = accept && legal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= 32'h0000_0000;
      addr_q      <= BASE;
      count_q     <= '0;
      full_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (start) begin
      // A pending write still drains at its latched address
      addr_q  <= BASE;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_HOLD: begin
          if (bus.mem_ready) begin
            state_q  <= ST_EMPTY;
            mem_we_q <= 1'b0;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end else begin
      if (write) begin
        state_q     <= ST_HOLD;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word;
        count_q     <= count_q + CNT_ONE;
        if (addr_q == TOP) begin
          full_q <= 1'b1;
        end else begin
          addr_q <= addr_q + ADDR_ONE;
        end
      end else if ((state_q == ST_HOLD) && bus.mem_ready) begin
        state_q  <= full_q ? ST_DONE : ST_EMPTY;
        mem_we_q <= 1'b0;
      end
      if (accept && !legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign count         = count_q;
  assign full          = full_q;
  assign err           = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - table-driven and sequence checks for instr_encoder
module tb_instr_encoder;
  import mips_enc_pkg::*;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] exp_word;
  } vec_t;

  logic clk;
  logic reset;
  logic start_a;
  logic start_b;
  logic [8:0] count_a;
  logic [2:0] count_b;
  logic full_a, full_b, err_a, err_b;

  int checks = 0;
  int errors = 0;
  vec_t vecs[8];

  instr_encoder_if #(.ADDR_WIDTH(8)) bus_a ();
  instr_encoder_if #(.ADDR_WIDTH(2)) bus_b ();

  instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .bus(bus_a.slave),
    .count(count_a), .full(full_a), .err(err_a)
  );

  instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .bus(bus_b.slave),
    .count(count_b), .full(full_b), .err(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.req_kind  = v.kind;
    bus_a.req_rs    = v.rs;
    bus_a.req_rt    = v.rt;
    bus_a.req_rd    = v.rd;
    bus_a.req_shamt = v.shamt;
    bus_a.req_funct = v.funct;
    bus_a.req_imm   = v.imm;
  endtask

  initial begin
    vecs[0] = '{2'd0, 5'd1,  5'd2,  5'd3,  5'd0,  ADD,   16'hABCD, 32'h0022_1820};
    vecs[1] = '{2'd1, 5'd0,  5'd8,  5'd5,  5'd7,  6'h3F, 16'h0005, 32'h2008_0005};
    vecs[2] = '{2'd2, 5'd8,  5'd9,  5'd0,  5'd0,  6'h00, 16'h00FF, 32'h3509_00FF};
    vecs[3] = '{2'd0, 5'd4,  5'd5,  5'd6,  5'd0,  SUB,   16'h0000, 32'h0085_3022};
    vecs[4] = '{2'd0, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 32'h03FF_FFFF};
    vecs[5] = '{2'd1, 5'd31, 5'd1,  5'd0,  5'd0,  6'h00, 16'hFFFF, 32'h23E1_FFFF};
    vecs[6] = '{2'd2, 5'd0,  5'd2,  5'd0,  5'd0,  6'h00, 16'h8000, 32'h3402_8000};
    vecs[7] = '{2'd0, 5'd7,  5'd8,  5'd9,  5'd0,  NOR,   16'h0000, 32'h00E8_4827};

    reset = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    drive_a(vecs[0]);
    bus_a.req_valid = 1'b0;
    bus_a.mem_ready = 1'b0;
    bus_b.req_valid = 1'b0;
    bus_b.mem_ready = 1'b0;
    bus_b.req_kind  = 2'd0;
    bus_b.req_rs    = 5'd1;
    bus_b.req_rt    = 5'd2;
    bus_b.req_rd    = 5'd3;
    bus_b.req_shamt = 5'd0;
    bus_b.req_funct = ADD;
    bus_b.req_imm   = 16'h0000;

    #1;
    bus_a.req_valid = 1'b1;
    #1;
    chk("rst_ready", bus_a.req_ready, 0);
    chk("rst_we", bus_a.mem_we, 0);
    chk("rst_addr", bus_a.mem_addr, 0);
    chk("rst_wdata", bus_a.mem_wdata, 0);
    chk("rst_count", count_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_err", err_a, 0);
    bus_a.req_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Back-to-back table, one word per cycle
    for (int i = 0; i < 8; i++) begin
      drive_a(vecs[i]);
      bus_a.req_valid = 1'b1;
      bus_a.mem_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ready", i), bus_a.req_ready, 1);
      tick();
      chk($sformatf("v%0d_we", i), bus_a.mem_we, 1);
      chk($sformatf("v%0d_wdata", i), bus_a.mem_wdata, vecs[i].exp_word);
      chk($sformatf("v%0d_addr", i), bus_a.mem_addr, i);
      chk($sformatf("v%0d_count", i), count_a, i + 1);
    end

    // Stall for three cycles in HOLD
    drive_a(vecs[0]);
    tick();
    chk("st_addr0", bus_a.mem_addr, 8);
    drive_a(vecs[1]);
    bus_a.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("st%0d_ready", k), bus_a.req_ready, 0);
      tick();
      chk($sformatf("st%0d_we", k), bus_a.mem_we, 1);
      chk($sformatf("st%0d_wdata", k), bus_a.mem_wdata, 32'h0022_1820);
      chk($sformatf("st%0d_addr", k), bus_a.mem_addr, 8);
    end
    bus_a.mem_ready = 1'b1;
    #1;
    chk("st_rise_ready", bus_a.req_ready, 1);
    tick();
    chk("st_next_wdata", bus_a.mem_wdata, 32'h2008_0005);
    chk("st_next_addr", bus_a.mem_addr, 9);
    chk("st_next_count", count_a, 10);
    bus_a.req_valid = 1'b0;
    tick();
    chk("st_drain_we", bus_a.mem_we, 0);

    // Kind 3 request
    bus_a.req_kind = 2'd3;
    bus_a.req_valid = 1'b1;
    tick();
    bus_a.req_valid = 1'b0;
`ifdef INSTR_ENC_CHECK_EN
    chk("ill_we", bus_a.mem_we, 0);
    chk("ill_err", err_a, 1);
    chk("ill_count", count_a, 10);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("ill_start_err", err_a, 0);
    bus_a.req_kind = 2'd1;
    bus_a.req_rt = 5'd0;
    bus_a.req_valid = 1'b1;
    tick();
    bus_a.req_valid = 1'b0;
    chk("zrt_we", bus_a.mem_we, 0);
    chk("zrt_err", err_a, 1);
    chk("zrt_count", count_a, 0);
`else
    chk("ill_we", bus_a.mem_we, 1);
    chk("ill_wdata", bus_a.mem_wdata, 32'h0000_0000);
    chk("ill_addr", bus_a.mem_addr, 10);
    chk("ill_err", err_a, 0);
    chk("ill_count", count_a, 11);
`endif
    tick();

    // start beats a simultaneous request
    drive_a(vecs[0]);
    bus_a.req_valid = 1'b1;
    start_a = 1'b1;
    #1;
    chk("sr_ready", bus_a.req_ready, 0);
    tick();
    chk("sr_we", bus_a.mem_we, 0);
    chk("sr_count", count_a, 0);
    chk("sr_err", err_a, 0);
    start_a = 1'b0;
    tick();
    chk("sr_next_we", bus_a.mem_we, 1);
    chk("sr_next_addr", bus_a.mem_addr, 0);
    chk("sr_next_count", count_a, 1);

    // Small memory fills up
    bus_b.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_b.req_valid = 1'b1;
      #1;
      chk($sformatf("f%0d_ready", i), bus_b.req_ready, (i < 4) ? 1 : 0);
      tick();
      chk($sformatf("f%0d_we", i), bus_b.mem_we, (i < 4) ? 1 : 0);
      if (i < 4) chk($sformatf("f%0d_addr", i), bus_b.mem_addr, i);
      chk($sformatf("f%0d_full", i), full_b, (i >= 3) ? 1 : 0);
      chk($sformatf("f%0d_count", i), count_b, (i < 4) ? i + 1 : 4);
    end
    bus_b.req_valid = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("fs_full", full_b, 0);
    chk("fs_count", count_b, 0);
    bus_b.req_valid = 1'b1;
    #1;
    chk("fs_ready", bus_b.req_ready, 1);
    tick();
    bus_b.req_valid = 1'b0;
    chk("fs_we", bus_b.mem_we, 1);
    chk("fs_addr", bus_b.mem_addr, 0);
    chk("fs_count1", count_b, 1);

    // Reset in the middle of a held write
    bus_a.req_valid = 1'b0;
    bus_a.mem_ready = 1'b0;
    tick();
    chk("rh_we_pre", bus_a.mem_we, 1);
    reset = 1'b0;
    #1;
    chk("rh_we", bus_a.mem_we, 0);
    chk("rh_count", count_a, 0);
    chk("rh_ready", bus_a.req_ready, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
